// File: rtl/rr_burst_mux_arbiter.sv
// rr_burst_mux_arbiter: round-robin burst arbiter muxing four valid/ready requesters onto one registered channel
module rr_burst_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  output logic               out_last
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, lock_src, lock_src_n, gnt;
  logic found, load, xfer;
  always_comb begin
    gnt = lock_src;
    found = (state == LOCKED) && in_valid[lock_src];
    // descending scan so the requester closest to ptr wins
    if (state == IDLE)
      for (int k = 3; k >= 0; k--)
        if (in_valid[ptr + 2'(k)]) begin
          gnt = ptr + 2'(k);
          found = 1'b1;
        end
    load = !out_valid || out_ready;
    xfer = load && found && !rst;
    in_ready = xfer ? 4'b0001 << gnt : 4'b0000;
    state_n = xfer ? (in_last[gnt] ? IDLE : LOCKED) : state;
    ptr_n = (xfer && in_last[gnt]) ? gnt + 2'd1 : ptr;
    lock_src_n = (xfer && !in_last[gnt]) ? gnt : lock_src;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      lock_src <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      lock_src <= lock_src_n;
      if (load) out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gnt*WIDTH +: WIDTH];
        out_src <= gnt;
        out_last <= in_last[gnt];
      end
    end
  end
endmodule
